// File: rtl/n2_icd_fill_wr.sv
// Instruction-cache fill writer: gathers four 64-bit CMU beats with per-instruction odd parity,
// then issues one full-line write through the IC data array BF-stage port, yielding to fetch reads.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no line in progress; next accepted beat is beat 0
// COLLECT | beats 1..3 outstanding; waits indefinitely between beats
// WAIT    | full line held; writes on the first read-free, uninhibited cycle
module n2_icd_fill_wr #(
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic         l2clk,
  input  logic         reset,
  input  logic         cmu_fill_vld,
  input  logic [63:0]  cmu_fill_data,
  input  logic [8:0]   cmu_fill_index,
  input  logic [2:0]   cmu_fill_way,
  output logic         cmu_fill_rdy,
  input  logic         ftp_ic_rd_req_bf,
  input  logic         tcu_array_wr_inhibit,
  output logic         ftp_ic_wr_req_bf,
  output logic [8:0]   agd_ic_index_bf,
  output logic [2:0]   agc_fill_wrway_bf,
  output logic [263:0] cmu_ic_data,
  output logic [7:0]   agc_word_en_bf,
  output logic         ftp_icd_quad_0_en_bf,
  output logic         ftp_icd_quad_1_en_bf,
  output logic         ftp_icd_quad_2_en_bf,
  output logic         ftp_icd_quad_3_en_bf,
  output logic         fill_stall_req,
  output logic         fill_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WAIT    = 2'd2
  } state_t;

  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIM);

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [3:0]     starve_q, starve_d;
  logic           beat_acc;
  logic           wr_req;
  logic [65:0]    beat_slots;
  logic [263:0]   data_q;
  logic [8:0]     index_q;
  logic [2:0]     way_q;
  logic           stall_q;
  logic           done_q;

  // Two 33-bit slots per beat: {par, instr}, odd instruction in the upper slot
  assign beat_slots = {~^cmu_fill_data[63:32], cmu_fill_data[63:32],
                       ~^cmu_fill_data[31:0],  cmu_fill_data[31:0]};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    starve_d     = starve_q;
    cmu_fill_rdy = (state_q != WAIT);
    beat_acc     = cmu_fill_vld & cmu_fill_rdy;
    wr_req       = (state_q == WAIT) & ~ftp_ic_rd_req_bf & ~tcu_array_wr_inhibit;
    case (state_q)
      IDLE: begin
        if (beat_acc) begin
          state_d = COLLECT;
          cnt_d   = 2'd1;
        end
      end
      COLLECT: begin
        if (beat_acc) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = WAIT;
        end
      end
      WAIT: begin
        if (wr_req) begin
          state_d  = IDLE;
          cnt_d    = 2'd0;
          starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
          starve_d = starve_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  always_ff @(posedge l2clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      starve_q <= 4'd0;
      data_q   <= '0;
      index_q  <= '0;
      way_q    <= '0;
      stall_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      if (beat_acc) begin
        data_q[66*cnt_q +: 66] <= beat_slots;
        if (state_q == IDLE) begin
          index_q <= cmu_fill_index;
          way_q   <= cmu_fill_way;
        end
      end
      // Registered from the next count so the request tracks the counter without extra lag
      stall_q  <= (starve_d >= STARVE_LIM4);
      done_q   <= wr_req;
    end
  end

  assign ftp_ic_wr_req_bf     = wr_req;
  assign agd_ic_index_bf      = index_q;
  assign agc_fill_wrway_bf    = way_q;
  assign cmu_ic_data          = data_q;
  assign agc_word_en_bf       = {8{wr_req}};
  assign ftp_icd_quad_0_en_bf = wr_req;
  assign ftp_icd_quad_1_en_bf = wr_req;
  assign ftp_icd_quad_2_en_bf = wr_req;
  assign ftp_icd_quad_3_en_bf = wr_req;
  assign fill_stall_req       = stall_q;
  assign fill_done            = done_q;

endmodule

// File: tb/tb_n2_icd_fill_wr.sv
// Directed bench for n2_icd_fill_wr: a scoreboard of expected lines is checked on every array write.
module tb_n2_icd_fill_wr;

  localparam int LIM = 8;

  logic         l2clk = 1'b0;
  logic         reset;
  logic         cmu_fill_vld;
  logic [63:0]  cmu_fill_data;
  logic [8:0]   cmu_fill_index;
  logic [2:0]   cmu_fill_way;
  logic         cmu_fill_rdy;
  logic         ftp_ic_rd_req_bf;
  logic         tcu_array_wr_inhibit;
  logic         ftp_ic_wr_req_bf;
  logic [8:0]   agd_ic_index_bf;
  logic [2:0]   agc_fill_wrway_bf;
  logic [263:0] cmu_ic_data;
  logic [7:0]   agc_word_en_bf;
  logic         q0, q1, q2, q3;
  logic         fill_stall_req;
  logic         fill_done;

  n2_icd_fill_wr #(.STARVE_LIM(LIM)) dut (
    .l2clk                (l2clk),
    .reset                (reset),
    .cmu_fill_vld         (cmu_fill_vld),
    .cmu_fill_data        (cmu_fill_data),
    .cmu_fill_index       (cmu_fill_index),
    .cmu_fill_way         (cmu_fill_way),
    .cmu_fill_rdy         (cmu_fill_rdy),
    .ftp_ic_rd_req_bf     (ftp_ic_rd_req_bf),
    .tcu_array_wr_inhibit (tcu_array_wr_inhibit),
    .ftp_ic_wr_req_bf     (ftp_ic_wr_req_bf),
    .agd_ic_index_bf      (agd_ic_index_bf),
    .agc_fill_wrway_bf    (agc_fill_wrway_bf),
    .cmu_ic_data          (cmu_ic_data),
    .agc_word_en_bf       (agc_word_en_bf),
    .ftp_icd_quad_0_en_bf (q0),
    .ftp_icd_quad_1_en_bf (q1),
    .ftp_icd_quad_2_en_bf (q2),
    .ftp_icd_quad_3_en_bf (q3),
    .fill_stall_req       (fill_stall_req),
    .fill_done            (fill_done)
  );

  always #5 l2clk = ~l2clk;

  typedef struct packed {
    logic [8:0]   idx;
    logic [2:0]   way;
    logic [263:0] data;
  } line_t;

  line_t       exp_q[$];
  logic [31:0] slots[8];
  int          errors = 0;
  int          checks = 0;
  int          wr_count = 0;

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [263:0] exp_data();
    logic [263:0] d;
    d = '0;
    for (int i = 0; i < 8; i++) d[33*i +: 33] = {~^slots[i], slots[i]};
    return d;
  endfunction

  task automatic tick();
    @(posedge l2clk);
    #1;
  endtask

  // Index/way are driven garbage on beats 1..3: only beat 0 may be sampled
  task automatic send_beat(input int k, input logic [8:0] idx, input logic [2:0] way);
    cmu_fill_vld   = 1'b1;
    cmu_fill_data  = {slots[2*k+1], slots[2*k]};
    cmu_fill_index = (k == 0) ? idx : ~idx;
    cmu_fill_way   = (k == 0) ? way : ~way;
    @(negedge l2clk);
    chk("rdy_on_beat", cmu_fill_rdy, 1'b1);
    tick();
    cmu_fill_vld  = 1'b0;
    cmu_fill_data = '0;
  endtask

  task automatic send_line(input logic [8:0] idx, input logic [2:0] way, input int gap);
    line_t l;
    l.idx  = idx;
    l.way  = way;
    l.data = exp_data();
    exp_q.push_back(l);
    for (int k = 0; k < 4; k++) begin
      send_beat(k, idx, way);
      if (k < 3) repeat (gap) tick();
    end
  endtask

  always @(negedge l2clk) begin
    if (ftp_ic_wr_req_bf === 1'b1) begin
      line_t l;
      wr_count++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", ftp_ic_wr_req_bf, 1'b0);
      end else begin
        l = exp_q.pop_front();
        chk("wr_index", agd_ic_index_bf, l.idx);
        chk("wr_way", agc_fill_wrway_bf, l.way);
        chk("wr_data", cmu_ic_data, l.data);
        chk("wr_word_en", agc_word_en_bf, 8'hFF);
        chk("wr_quad_en", {q3, q2, q1, q0}, 4'hF);
      end
    end else begin
      chk("idle_word_en", agc_word_en_bf, 8'h00);
      chk("idle_quad_en", {q3, q2, q1, q0}, 4'h0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    cmu_fill_vld = 1'b0;
    cmu_fill_data = '0;
    cmu_fill_index = '0;
    cmu_fill_way = '0;
    ftp_ic_rd_req_bf = 1'b0;
    tcu_array_wr_inhibit = 1'b0;
    repeat (2) tick();
    chk("rst_rdy", cmu_fill_rdy, 1'b1);
    chk("rst_wr", ftp_ic_wr_req_bf, 1'b0);
    chk("rst_stall", fill_stall_req, 1'b0);
    chk("rst_done", fill_done, 1'b0);
    chk("rst_index", agd_ic_index_bf, 9'h0);
    chk("rst_way", agc_fill_wrway_bf, 3'h0);
    chk("rst_data", cmu_ic_data, 264'h0);
    reset = 1'b0;

    // Line 1: contiguous beats, write at cycle 4, done at cycle 5
    for (int i = 0; i < 8; i++) slots[i] = 32'h1111_1111 * (i + 1);
    send_line(9'h1A5, 3'd3, 0);
    @(negedge l2clk);
    chk("l1_wr_c4", ftp_ic_wr_req_bf, 1'b1);
    chk("l1_rdy_c4", cmu_fill_rdy, 1'b0);
    chk("l1_par_slot7", cmu_ic_data[263:231], {1'b1, 32'h8888_8888});
    tick();
    @(negedge l2clk);
    chk("l1_done_c5", fill_done, 1'b1);
    chk("l1_rdy_c5", cmu_fill_rdy, 1'b1);
    chk("l1_wr_c5", ftp_ic_wr_req_bf, 1'b0);
    tick();

    // Line 2: read wins for cycles 4..6, write at 7
    for (int i = 0; i < 8; i++) slots[i] = $urandom;
    send_line(9'h0F3, 3'd5, 0);
    for (int c = 4; c <= 8; c++) begin
      ftp_ic_rd_req_bf = (c <= 6);
      @(negedge l2clk);
      chk("rd_wr", ftp_ic_wr_req_bf, c == 7);
      chk("rd_rdy", cmu_fill_rdy, c == 8);
      chk("rd_done", fill_done, c == 8);
      tick();
    end

    // Line 3: starvation with reads on cycles 4..15
    for (int i = 0; i < 8; i++) slots[i] = $urandom;
    send_line(9'h155, 3'd1, 0);
    for (int c = 4; c <= 17; c++) begin
      ftp_ic_rd_req_bf = (c <= 15);
      @(negedge l2clk);
      chk("stv_stall", fill_stall_req, (c >= 4 + LIM) && (c <= 16));
      chk("stv_wr", ftp_ic_wr_req_bf, c == 16);
      chk("stv_done", fill_done, c == 17);
      tick();
    end

    // Line 4: array write inhibit on cycles 4..5
    for (int i = 0; i < 8; i++) slots[i] = $urandom;
    send_line(9'h0AA, 3'd6, 0);
    for (int c = 4; c <= 7; c++) begin
      tcu_array_wr_inhibit = (c <= 5);
      @(negedge l2clk);
      chk("inh_wr", ftp_ic_wr_req_bf, c == 6);
      chk("inh_done", fill_done, c == 7);
      tick();
    end

    // Lines 5/6: spaced beats, then next line starts in the fill_done cycle
    for (int i = 0; i < 8; i++) slots[i] = $urandom;
    send_line(9'h1FF, 3'd7, 2);
    @(negedge l2clk);
    chk("gap_wr_c10", ftp_ic_wr_req_bf, 1'b1);
    tick();
    chk("gap_done_c11", fill_done, 1'b1);
    chk("gap_rdy_c11", cmu_fill_rdy, 1'b1);
    for (int i = 0; i < 8; i++) slots[i] = $urandom;
    send_line(9'h002, 3'd2, 0);
    @(negedge l2clk);
    chk("b2b_wr", ftp_ic_wr_req_bf, 1'b1);
    tick();
    tick();

    // Reset after beat 2 discards the partial line
    for (int i = 0; i < 8; i++) slots[i] = 32'hDEAD_0000 | i;
    for (int k = 0; k < 3; k++) send_beat(k, 9'h0CC, 3'd4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_data", cmu_fill_data === '0 ? cmu_ic_data : 264'h1, 264'h0);
    chk("mid_rst_rdy", cmu_fill_rdy, 1'b1);
    repeat (5) begin
      @(negedge l2clk);
      chk("mid_rst_nowr", ftp_ic_wr_req_bf, 1'b0);
      tick();
    end
    slots[0] = 32'h0;
    for (int i = 1; i < 8; i++) slots[i] = $urandom;
    send_line(9'h133, 3'd0, 0);
    @(negedge l2clk);
    chk("post_rst_wr", ftp_ic_wr_req_bf, 1'b1);
    chk("zero_instr_par", cmu_ic_data[32:0], 33'h1_0000_0000);
    tick();
    repeat (2) tick();

    chk("sb_empty", exp_q.size(), 0);
    chk("wr_total", wr_count, 7);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
